// File: rtl/uart_rx_cfg.sv
// UART receiver: 2-flop input synchronizer, start/data/stop framing FSM and a
// one-word output register with valid/ready handshake and overrun flag.
// Optional parity stage is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_rx,
    input  logic                 i_ready,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    output logic                 o_busy
);

    localparam int             CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [3:0]     DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 ||
        STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
        $error("uart_rx_cfg: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_HIGH
    } state_e;

    state_e                 state_q, state_d;
    logic                   rx_meta_q, rx_sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [3:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   ferr_acc_q, ferr_acc_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic                   overrun_q, overrun_d;
    logic                   load;
    logic                   transfer;
    logic                   perr_w;

`ifdef UART_RX_PARITY_EN
    logic par_bit_q, par_bit_d;
    assign perr_w = ((^shift_q) ^ par_bit_q) != 1'(PARITY_ODD);
`else
    assign perr_w = 1'b0;
`endif

    assign transfer = valid_q & i_ready;

    // NOTE: every variable gets a default at the top of always_comb so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        ferr_acc_d = ferr_acc_q;
        load       = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d  = par_bit_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (!rx_sync_q) begin
                    state_d    = S_START;
                    ferr_acc_d = 1'b0;
                end
            end
            S_START: begin
                if (cnt_q == CNT_HALF) state_d = rx_sync_q ? S_IDLE : S_DATA;
                else                   cnt_d   = cnt_q + CNT_W'(1);
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 4'd1;
                    if (bit_q == DATA_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    par_bit_d = rx_sync_q;
                    state_d   = S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d      = '0;
                    bit_d      = bit_q + 4'd1;
                    ferr_acc_d = ferr_acc_q | ~rx_sync_q;
                    if (bit_q == STOP_LAST) begin
                        load    = 1'b1;
                        state_d = rx_sync_q ? S_IDLE : S_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_HIGH: begin
                if (rx_sync_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
            bit_d = '0;
        end

        // A load in the same cycle as a transfer replaces the word cleanly;
        // only a load onto an unaccepted word counts as an overrun.
        data_d    = data_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        valid_d   = valid_q & ~i_ready;
        overrun_d = transfer ? 1'b0 : overrun_q;
        if (load) begin
            data_d  = shift_q;
            perr_d  = perr_w;
            ferr_d  = ferr_acc_d;
            valid_d = 1'b1;
            if (valid_q && !i_ready) overrun_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            ferr_acc_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q  <= 1'b0;
`endif
        end else begin
            // i_rx is asynchronous; only rx_sync_q is used by the FSM.
            rx_meta_q  <= i_rx;
            rx_sync_q  <= rx_meta_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            ferr_acc_q <= ferr_acc_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            overrun_q  <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q  <= par_bit_d;
`endif
        end
    end

    assign o_data       = data_q;
    assign o_valid      = valid_q;
    assign o_parity_err = perr_q;
    assign o_frame_err  = ferr_q;
    assign o_overrun    = overrun_q;
    assign o_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: directed scenarios plus random frames;
// a monitor pops expected words on every valid/ready transfer.
module tb_uart_rx_cfg;

    localparam int CLKS   = 64;
    localparam int DB     = 8;
    localparam int SB     = 1;
    localparam int PODD   = 1;
    localparam int GLITCH = CLKS / 2 - 12;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_rx = 1'b1;
    logic          i_ready = 1'b1;
    logic [DB-1:0] o_data;
    logic          o_valid, o_parity_err, o_frame_err, o_overrun, o_busy;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       ovr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass = 0;
    bit   rand_ready = 1'b0;

    uart_rx_cfg #(
        .CLKS_PER_BIT(CLKS),
        .DATA_BITS   (DB),
        .STOP_BITS   (SB),
        .PARITY_ODD  (PODD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_rx        (i_rx),
        .i_ready     (i_ready),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_parity_err(o_parity_err),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic lvl);
        i_rx = lvl;
        repeat (CLKS) tick();
    endtask

    task automatic idle_bits(input int n);
        i_rx = 1'b1;
        repeat (n * CLKS) tick();
    endtask

    function automatic logic good_pbit(input logic [7:0] d);
        return (PODD != 0) ? ~(^d) : (^d);
    endfunction

    // Reference model: the word as sent, frame error iff stop sampled low,
    // parity error iff XOR(data, parity bit) differs from the odd/even setting.
    task automatic push_exp(input logic [7:0] d, input logic pbit, input logic stop_lvl,
                            input logic ovr);
        exp_t e;
        e.data = d;
        e.ferr = (stop_lvl == 1'b0);
        e.perr = PAR_EN && (((^d) ^ pbit) != (PODD != 0));
        e.ovr  = ovr;
        exp_q.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop_lvl,
                              input int extra_low);
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) drive_bit(d[i]);
        if (PAR_EN) drive_bit(pbit);
        for (int s = 0; s < SB; s++) drive_bit(stop_lvl);
        for (int k = 0; k < extra_low; k++) drive_bit(1'b0);
        i_rx = 1'b1;
    endtask

    // Monitor: any transfer must match the oldest expected word.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && o_valid && i_ready) begin
                check("sb_word_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("sb_data", 32'(o_data), 32'(mon_e.data));
                    check("sb_parity_err", 32'(o_parity_err), 32'(mon_e.perr));
                    check("sb_frame_err", 32'(o_frame_err), 32'(mon_e.ferr));
                    check("sb_overrun", 32'(o_overrun), 32'(mon_e.ovr));
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) i_ready = ($urandom_range(0, 1) == 1);
        end
    end

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic       pbit, stop_lvl, busy_seen;
        int         n;

        // Reset state
        repeat (3) tick();
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_data", 32'(o_data), 32'd0);
        check("rst_flags", 32'({o_parity_err, o_frame_err, o_overrun}), 32'd0);
        rst_n = 1'b1;
        idle_bits(2);

        // Clean frame 0x3F
        push_exp(8'h3F, good_pbit(8'h3F), 1'b1, 1'b0);
        send_frame(8'h3F, good_pbit(8'h3F), 1'b1, 0);
        idle_bits(2);

        // Short low glitch on idle line
        busy_seen = 1'b0;
        i_rx = 1'b0;
        for (int i = 0; i < GLITCH; i++) begin
            tick();
            busy_seen |= o_busy;
        end
        i_rx = 1'b1;
        n = 0;
        while (o_busy && n < (CLKS / 2 + 8) - GLITCH) begin
            tick();
            n++;
        end
        check("glitch_busy_seen", 32'(busy_seen), 32'd1);
        check("glitch_busy_clear", 32'(o_busy), 32'd0);
        idle_bits(2);

        // Low stop bit, line held low 5 bit periods, then a clean frame
        push_exp(8'hA5, good_pbit(8'hA5), 1'b0, 1'b0);
        send_frame(8'hA5, good_pbit(8'hA5), 1'b0, 4);
        idle_bits(2);
        push_exp(8'h12, good_pbit(8'h12), 1'b1, 1'b0);
        send_frame(8'h12, good_pbit(8'h12), 1'b1, 0);
        idle_bits(2);

`ifdef UART_RX_PARITY_EN
        push_exp(8'h3F, 1'b0, 1'b1, 1'b0);
        send_frame(8'h3F, 1'b0, 1'b1, 0);
        idle_bits(2);
        push_exp(8'h3F, 1'b1, 1'b1, 1'b0);
        send_frame(8'h3F, 1'b1, 1'b1, 0);
        idle_bits(2);
`endif

        // Overrun: two words with the consumer stalled
        i_ready = 1'b0;
        send_frame(8'h11, good_pbit(8'h11), 1'b1, 0);
        idle_bits(1);
        send_frame(8'h22, good_pbit(8'h22), 1'b1, 0);
        idle_bits(1);
        check("ovr_valid", 32'(o_valid), 32'd1);
        check("ovr_data", 32'(o_data), 32'h22);
        check("ovr_flag", 32'(o_overrun), 32'd1);
        push_exp(8'h22, good_pbit(8'h22), 1'b1, 1'b1);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        tick();
        check("ovr_valid_cleared", 32'(o_valid), 32'd0);
        check("ovr_flag_cleared", 32'(o_overrun), 32'd0);
        i_ready = 1'b1;
        idle_bits(1);

        // Reset in the middle of data bit 4 of 0x55
        d = 8'h55;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        i_rx = d[4];
        repeat (CLKS / 2) tick();
        rst_n = 1'b0;
        tick();
        check("midrst_busy", 32'(o_busy), 32'd0);
        check("midrst_valid", 32'(o_valid), 32'd0);
        check("midrst_data", 32'(o_data), 32'd0);
        i_rx = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        idle_bits(2);
        push_exp(8'hC3, good_pbit(8'hC3), 1'b1, 1'b0);
        send_frame(8'hC3, good_pbit(8'hC3), 1'b1, 0);
        idle_bits(2);

        // Random frames with a randomly stalling consumer
        rand_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            d        = 8'($urandom_range(0, 255));
            pbit     = PAR_EN ? 1'($urandom_range(0, 1)) : good_pbit(d);
            stop_lvl = ($urandom_range(0, 3) != 0);
            push_exp(d, pbit, stop_lvl, 1'b0);
            send_frame(d, pbit, stop_lvl, stop_lvl ? 0 : int'($urandom_range(0, 2)));
            idle_bits(int'($urandom_range(1, 3)));
        end
        rand_ready = 1'b0;
        i_ready = 1'b1;

        n = 0;
        while (exp_q.size() != 0 && n < 4 * CLKS) begin
            tick();
            n++;
        end
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        check("end_busy", 32'(o_busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
